// File: rtl/fbs_pkg.sv
// rtl/fbs_pkg.sv - shared types, widths and helpers for the frame buffer scheduler
//
// Purpose: FSM state and grant encodings, bus widths and the frame size helper
// used by frame_buf_scheduler, its arbiter and its memory-port interface.
package fbs_pkg;

  localparam int CNT_W  = 19;  // word counters; must hold FRAME_WORDS
  localparam int ADDR_W = 24;  // SDRAM word address
  localparam int LEN_W  = 9;   // burst length field
  localparam int LVL_W  = 11;  // FIFO level inputs (0..1024)

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } fsm_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  function automatic int frame_words(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/frame_buf_scheduler_if.sv
// rtl/frame_buf_scheduler_if.sv - SDRAM burst port between scheduler and memory controller
//
// Purpose: groups the burst request/acknowledge signals.
// Ports (signals):
//   mem_wr_req / mem_rd_req : burst requests, held until mem_ack
//   mem_addr                : burst start word address
//   mem_burst_len           : words per burst
//   mem_ack                 : one-cycle pulse, request accepted
//   mem_done                : one-cycle pulse, burst transfer complete
// Modports: master = scheduler side, slave = memory controller side.
interface frame_buf_scheduler_if;
  import fbs_pkg::*;

  logic              mem_wr_req;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_burst_len;
  logic              mem_ack;
  logic              mem_done;

  modport master (
    output mem_wr_req, mem_rd_req, mem_addr, mem_burst_len,
    input  mem_ack, mem_done
  );

  modport slave (
    input  mem_wr_req, mem_rd_req, mem_addr, mem_burst_len,
    output mem_ack, mem_done
  );

endinterface

// File: rtl/fbs_arbiter.sv
// rtl/fbs_arbiter.sv - priority / round-robin pick between write and read bursts
//
// Purpose: combinational grant decision for the single SDRAM burst port.
// Ports:
//   wr_elig     in  : write FIFO holds a burst and the write frame is unfinished
//   rd_room     in  : read FIFO has room for a burst and a previous frame is readable
//   rd_urg      in  : rd_room and the read FIFO is below its low watermark
//   last_grant  in  : type of the last completed burst
//   grant_valid out : some burst should be issued
//   grant       out : which one
module fbs_arbiter
  import fbs_pkg::*;
(
  input  logic   wr_elig,
  input  logic   rd_room,
  input  logic   rd_urg,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  always_comb begin
    grant_valid = 1'b0;
    grant       = GRANT_WR;
    if (rd_urg) begin
      // a starving read side would stall the difference pipeline
      grant_valid = 1'b1;
      grant       = GRANT_RD;
    end else if (wr_elig && rd_room) begin
      grant_valid = 1'b1;
      grant       = (last_grant == GRANT_WR) ? GRANT_RD : GRANT_WR;
    end else if (wr_elig) begin
      grant_valid = 1'b1;
      grant       = GRANT_WR;
    end else if (rd_room) begin
      grant_valid = 1'b1;
      grant       = GRANT_RD;
    end
  end

endmodule

// File: rtl/frame_buf_scheduler.sv
// rtl/frame_buf_scheduler.sv - ping-pong SDRAM frame buffer burst scheduler
//
// Purpose: writes the current frame into one bank while reading the previous
// frame from the other, arbitrating the single burst port and swapping banks
// at frame boundaries.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   frame_vsync      : frame sync, rising edge = frame start
//   wr_fifo_level    : words in the write FIFO
//   rd_fifo_level    : words in the read FIFO
//   mem              : SDRAM burst port (master modport)
//   wr_bank          : bank being written; the read bank is its complement
//   prev_valid       : read bank holds a complete previous frame
//   frame_cnt        : completed-frame counter
//   frame_drop       : pulse, frame boundary arrived before the frame was written
module frame_buf_scheduler
  import fbs_pkg::*;
#(
  parameter int          IMG_HDISP  = 640,
  parameter int          IMG_VDISP  = 480,
  parameter int          BURST_LEN  = 256,
  parameter int          FIFO_DEPTH = 1024,
  parameter int          RD_LOW_WM  = 128,
  parameter logic [23:0] BANK0_BASE = 24'h000000,
  parameter logic [23:0] BANK1_BASE = 24'h080000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_vsync,
  input  logic [LVL_W-1:0]     wr_fifo_level,
  input  logic [LVL_W-1:0]     rd_fifo_level,
  frame_buf_scheduler_if.master mem,
  output logic                 wr_bank,
  output logic                 prev_valid,
  output logic [15:0]          frame_cnt,
  output logic                 frame_drop
);

  localparam int FRAME_WORDS = frame_words(IMG_HDISP, IMG_VDISP);

  if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_burst
    $error("FRAME_WORDS must be a multiple of BURST_LEN");
  end
  if (FRAME_WORDS >= (1 << CNT_W) || BURST_LEN >= (1 << LEN_W)) begin : g_bad_width
    $error("frame or burst size exceeds counter width");
  end

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] CNT_STEP   = CNT_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] WR_MIN_LVL = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] RD_MAX_LVL = LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [LVL_W-1:0] RD_URG_LVL = LVL_W'(RD_LOW_WM);

  fsm_state_t        state, state_next;
  grant_t            last_grant, grant;
  logic              grant_valid;
  logic              vsync_d, vs_rise, swap_pend;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt, wr_cnt_add, rd_cnt_add;
  logic              wr_elig, rd_room, rd_urg;
  logic              do_swap, start_wr, start_rd, wr_fin, rd_fin;
  logic [ADDR_W-1:0] wr_base, rd_base;

  assign vs_rise    = frame_vsync & ~vsync_d;
  assign wr_elig    = (wr_fifo_level >= WR_MIN_LVL) && (wr_cnt < CNT_FULL);
  assign rd_room    = (rd_fifo_level <= RD_MAX_LVL) && prev_valid && (rd_cnt < CNT_FULL);
  assign rd_urg     = rd_room && (rd_fifo_level < RD_URG_LVL);
  assign wr_base    = wr_bank ? BANK1_BASE : BANK0_BASE;
  assign rd_base    = wr_bank ? BANK0_BASE : BANK1_BASE;
  assign wr_cnt_add = wr_cnt + CNT_STEP;
  assign rd_cnt_add = rd_cnt + CNT_STEP;

  assign mem.mem_wr_req    = (state == WR_REQ);
  assign mem.mem_rd_req    = (state == RD_REQ);
  assign mem.mem_burst_len = LEN_W'(BURST_LEN);

  fbs_arbiter u_arbiter (
    .wr_elig     (wr_elig),
    .rd_room     (rd_room),
    .rd_urg      (rd_urg),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    state_next = state;
    do_swap    = 1'b0;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    wr_fin     = 1'b0;
    rd_fin     = 1'b0;
    case (state)
      IDLE: begin
        // the swap only happens between bursts, and owns its cycle
        if (swap_pend) begin
          do_swap = 1'b1;
        end else if (grant_valid) begin
          if (grant == GRANT_WR) begin
            start_wr   = 1'b1;
            state_next = WR_REQ;
          end else begin
            start_rd   = 1'b1;
            state_next = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mem.mem_ack) begin
          wr_fin     = mem.mem_done;
          state_next = mem.mem_done ? IDLE : WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem.mem_done) begin
          wr_fin     = 1'b1;
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        if (mem.mem_ack) begin
          rd_fin     = mem.mem_done;
          state_next = mem.mem_done ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem.mem_done) begin
          rd_fin     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      vsync_d      <= 1'b0;
      swap_pend    <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      last_grant   <= GRANT_RD;
      wr_bank      <= 1'b0;
      prev_valid   <= 1'b0;
      frame_cnt    <= '0;
      frame_drop   <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      state      <= state_next;
      vsync_d    <= frame_vsync;
      frame_drop <= 1'b0;

      // a further rising edge while a swap is pending is absorbed
      if (do_swap) swap_pend <= 1'b0;
      else if (vs_rise) swap_pend <= 1'b1;

      if (do_swap) begin
        wr_bank    <= ~wr_bank;
        wr_cnt     <= '0;
        rd_cnt     <= '0;
        frame_cnt  <= frame_cnt + 16'd1;
        prev_valid <= (wr_cnt == CNT_FULL);
        frame_drop <= (wr_cnt != CNT_FULL);
      end

      if (start_wr) mem.mem_addr <= wr_base + {{(ADDR_W-CNT_W){1'b0}}, wr_cnt};
      if (start_rd) mem.mem_addr <= rd_base + {{(ADDR_W-CNT_W){1'b0}}, rd_cnt};

      if (wr_fin) begin
        wr_cnt     <= (wr_cnt_add >= CNT_FULL) ? CNT_FULL : wr_cnt_add;
        last_grant <= GRANT_WR;
      end
      if (rd_fin) begin
        rd_cnt     <= (rd_cnt_add >= CNT_FULL) ? CNT_FULL : rd_cnt_add;
        last_grant <= GRANT_RD;
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// tb/tb_frame_buf_scheduler.sv - directed self-checking bench for frame_buf_scheduler
module tb_frame_buf_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_vsync = 1'b0;
  logic [10:0] wr_fifo_level = '0;
  logic [10:0] rd_fifo_level = '0;
  logic        wr_bank, prev_valid, frame_drop;
  logic [15:0] frame_cnt;

  int checks = 0;
  int passes = 0;
  int drop_cnt = 0;
  int both_cnt = 0;

  frame_buf_scheduler_if mem_if();

  frame_buf_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_vsync   (frame_vsync),
    .wr_fifo_level (wr_fifo_level),
    .rd_fifo_level (rd_fifo_level),
    .mem           (mem_if),
    .wr_bank       (wr_bank),
    .prev_valid    (prev_valid),
    .frame_cnt     (frame_cnt),
    .frame_drop    (frame_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_drop) drop_cnt++;
    if (mem_if.mem_wr_req && mem_if.mem_rd_req) both_cnt++;
  end

  task automatic wait_req(output bit is_rd, output logic [23:0] addr, output bit timeout);
    timeout = 1'b1;
    is_rd   = 1'b0;
    addr    = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_if.mem_wr_req || mem_if.mem_rd_req) begin
        timeout = 1'b0;
        is_rd   = mem_if.mem_rd_req;
        addr    = mem_if.mem_addr;
        break;
      end
    end
  endtask

  task automatic serve_burst(input bit same_cycle);
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_done = same_cycle;
    @(negedge clk);
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_done = 1'b0;
    if (!same_cycle) begin
      mem_if.mem_done = 1'b1;
      @(negedge clk);
      mem_if.mem_done = 1'b0;
    end
  endtask

  task automatic run_writes(input int n, input logic [23:0] base, output int bad);
    bit r, to;
    logic [23:0] a;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      wait_req(r, a, to);
      if (to) begin
        bad += n - k;
        break;
      end
      if (r || a !== base + 24'(k * 256)) bad++;
      serve_burst(1'b0);
    end
  endtask

  task automatic count_reqs(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mem_if.mem_wr_req || mem_if.mem_rd_req) seen++;
    end
  endtask

  task automatic test_reset;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_if.mem_wr_req, mem_if.mem_rd_req, mem_if.mem_addr, wr_bank, prev_valid, frame_cnt, frame_drop} !== '0)
      $display("FAIL reset_outputs: got wr=%b rd=%b addr=%h bank=%b pv=%b fc=%0d drop=%b, want all 0",
               mem_if.mem_wr_req, mem_if.mem_rd_req, mem_if.mem_addr, wr_bank, prev_valid, frame_cnt, frame_drop);
    else passes++;
    checks++;
    if (mem_if.mem_burst_len !== 9'd256)
      $display("FAIL reset_burst_len: got %0d want 256", mem_if.mem_burst_len);
    else passes++;
  endtask

  task automatic test_first_frame;
    int bad, seen;
    wr_fifo_level = 11'd300;
    rd_fifo_level = 11'd0;
    rst_n = 1'b1;
    run_writes(1200, 24'h000000, bad);
    checks++;
    if (bad !== 0) $display("FAIL frame1_writes: bad bursts %0d want 0", bad);
    else passes++;
    checks++;
    if (prev_valid !== 1'b0) $display("FAIL frame1_prev_valid: got %b want 0", prev_valid);
    else passes++;
    count_reqs(20, seen);
    checks++;
    if (seen !== 0) $display("FAIL frame1_saturated: got %0d request cycles want 0", seen);
    else passes++;
    rd_fifo_level = 11'd100;
    frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    frame_vsync = 1'b0;
    checks++;
    if ({wr_bank, prev_valid, frame_cnt, frame_drop} !== {1'b1, 1'b1, 16'd1, 1'b0})
      $display("FAIL swap1: got bank=%b pv=%b fc=%0d drop=%b want bank=1 pv=1 fc=1 drop=0",
               wr_bank, prev_valid, frame_cnt, frame_drop);
    else passes++;
  endtask

  task automatic test_urgent_and_round_robin;
    logic [10:0] lvl [10]  = '{100, 100, 100, 128, 128, 128, 500, 769, 769, 768};
    bit          erd [10]  = '{1, 1, 1, 0, 1, 0, 1, 0, 0, 1};
    logic [23:0] eadr [10] = '{24'h000000, 24'h000100, 24'h000200, 24'h080000, 24'h000300,
                               24'h080100, 24'h000400, 24'h080200, 24'h080300, 24'h000500};
    bit r, to;
    logic [23:0] a;
    for (int k = 0; k < 10; k++) begin
      rd_fifo_level = lvl[k];
      wait_req(r, a, to);
      checks++;
      if (to || r !== erd[k])
        $display("FAIL arb_type[%0d]: got rd=%b timeout=%b want rd=%b", k, r, to, erd[k]);
      else passes++;
      checks++;
      if (a !== eadr[k]) $display("FAIL arb_addr[%0d]: got %h want %h", k, a, eadr[k]);
      else passes++;
      if (!to) serve_burst(1'b0);
    end
  endtask

  task automatic test_swap_during_wait;
    bit r, to;
    logic [23:0] a;
    int seen;
    rd_fifo_level = 11'd1000;
    wr_fifo_level = 11'd300;
    wait_req(r, a, to);
    checks++;
    if (to || r || a !== 24'h080400)
      $display("FAIL sww_req: got rd=%b to=%b addr=%h want write at 080400", r, to, a);
    else passes++;
    mem_if.mem_ack = 1'b1;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    frame_vsync = 1'b1;
    @(negedge clk);
    frame_vsync = 1'b0;
    @(negedge clk);
    frame_vsync = 1'b1;
    @(negedge clk);
    frame_vsync = 1'b0;
    checks++;
    if ({wr_bank, frame_cnt} !== {1'b1, 16'd1})
      $display("FAIL sww_no_early_swap: got bank=%b fc=%0d want bank=1 fc=1", wr_bank, frame_cnt);
    else passes++;
    mem_if.mem_done = 1'b1;
    wr_fifo_level = 11'd0;
    @(negedge clk);
    mem_if.mem_done = 1'b0;
    checks++;
    if (wr_bank !== 1'b1) $display("FAIL sww_done_cycle: got bank=%b want 1", wr_bank);
    else passes++;
    @(negedge clk);
    checks++;
    if ({wr_bank, prev_valid, frame_cnt, frame_drop} !== {1'b0, 1'b0, 16'd2, 1'b1})
      $display("FAIL sww_swap: got bank=%b pv=%b fc=%0d drop=%b want bank=0 pv=0 fc=2 drop=1",
               wr_bank, prev_valid, frame_cnt, frame_drop);
    else passes++;
    count_reqs(12, seen);
    checks++;
    if ({frame_cnt, wr_bank, frame_drop} !== {16'd2, 1'b0, 1'b0} || seen !== 0)
      $display("FAIL sww_single_swap: got fc=%0d bank=%b drop=%b reqs=%0d want fc=2 bank=0 drop=0 reqs=0",
               frame_cnt, wr_bank, frame_drop, seen);
    else passes++;
  endtask

  task automatic test_frame_drop;
    int bad, seen, drops0;
    bit r, to;
    logic [23:0] a;
    wr_fifo_level = 11'd300;
    rd_fifo_level = 11'd0;
    run_writes(600, 24'h000000, bad);
    checks++;
    if (bad !== 0) $display("FAIL drop_writes: bad bursts %0d want 0", bad);
    else passes++;
    wr_fifo_level = 11'd0;
    drops0 = drop_cnt;
    frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    frame_vsync = 1'b0;
    checks++;
    if ({wr_bank, prev_valid, frame_cnt, frame_drop} !== {1'b1, 1'b0, 16'd3, 1'b1})
      $display("FAIL drop_swap: got bank=%b pv=%b fc=%0d drop=%b want bank=1 pv=0 fc=3 drop=1",
               wr_bank, prev_valid, frame_cnt, frame_drop);
    else passes++;
    count_reqs(20, seen);
    checks++;
    if (seen !== 0 || drop_cnt - drops0 !== 1)
      $display("FAIL drop_quiet: got reqs=%0d drops=%0d want reqs=0 drops=1", seen, drop_cnt - drops0);
    else passes++;
    wr_fifo_level = 11'd300;
    wait_req(r, a, to);
    checks++;
    if (to || r || a !== 24'h080000)
      $display("FAIL drop_no_read: got rd=%b to=%b addr=%h want write at 080000", r, to, a);
    else passes++;
    if (!to) serve_burst(1'b0);
  endtask

  task automatic test_same_cycle_and_reset;
    int bad;
    bit r, to;
    logic [23:0] a;
    run_writes(1199, 24'h080100, bad);
    checks++;
    if (bad !== 0) $display("FAIL frame4_writes: bad bursts %0d want 0", bad);
    else passes++;
    wr_fifo_level = 11'd0;
    rd_fifo_level = 11'd500;
    frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    frame_vsync = 1'b0;
    checks++;
    if ({wr_bank, prev_valid, frame_cnt} !== {1'b0, 1'b1, 16'd4})
      $display("FAIL swap4: got bank=%b pv=%b fc=%0d want bank=0 pv=1 fc=4", wr_bank, prev_valid, frame_cnt);
    else passes++;
    wait_req(r, a, to);
    checks++;
    if (to || !r || a !== 24'h080000)
      $display("FAIL sc_first_read: got rd=%b to=%b addr=%h want read at 080000", r, to, a);
    else passes++;
    serve_burst(1'b1);
    checks++;
    if (mem_if.mem_rd_req !== 1'b0) $display("FAIL sc_req_drop: got rd_req=%b want 0", mem_if.mem_rd_req);
    else passes++;
    @(negedge clk);
    checks++;
    if (mem_if.mem_rd_req !== 1'b1 || mem_if.mem_addr !== 24'h080100)
      $display("FAIL sc_next_read: got rd_req=%b addr=%h want 1 at 080100", mem_if.mem_rd_req, mem_if.mem_addr);
    else passes++;
    mem_if.mem_ack = 1'b1;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_if.mem_wr_req, mem_if.mem_rd_req, mem_if.mem_addr, wr_bank, prev_valid, frame_cnt, frame_drop} !== '0
        || mem_if.mem_burst_len !== 9'd256)
      $display("FAIL midburst_reset: got wr=%b rd=%b addr=%h bank=%b pv=%b fc=%0d len=%0d want all 0, len 256",
               mem_if.mem_wr_req, mem_if.mem_rd_req, mem_if.mem_addr, wr_bank, prev_valid, frame_cnt,
               mem_if.mem_burst_len);
    else passes++;
    rst_n = 1'b1;
    wr_fifo_level = 11'd300;
    rd_fifo_level = 11'd0;
    wait_req(r, a, to);
    checks++;
    if (to || r || a !== 24'h000000)
      $display("FAIL post_reset_write: got rd=%b to=%b addr=%h want write at 000000", r, to, a);
    else passes++;
    if (!to) serve_burst(1'b0);
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt !== 0) $display("FAIL req_exclusive: got %0d cycles with both requests want 0", both_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_urgent_and_round_robin();
    test_swap_during_wait();
    test_frame_drop();
    test_same_cycle_and_reset();
    test_exclusive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_buf_scheduler.md
Name: frame_buf_scheduler

Overview:
- Sequences the shared SDRAM frame buffer behind the frame-difference pipeline.
- Writes the current grey frame into one bank while the previous frame is read back from the other bank for frame_adjacent_sync.
- Arbitrates the single SDRAM burst port between the write FIFO (current pixels) and the read FIFO (previous pixels).
- Swaps banks on each frame boundary and flags when a valid previous frame exists.

Parameters:
- IMG_HDISP, 640, active pixels per line.
- IMG_VDISP, 480, active lines per frame. FRAME_WORDS = IMG_HDISP*IMG_VDISP = 307200.
- BURST_LEN, 256, words per SDRAM burst. Elaboration error if FRAME_WORDS % BURST_LEN != 0.
- FIFO_DEPTH, 1024, depth of both external FIFOs.
- RD_LOW_WM, 128, read-FIFO level below which a read is urgent.
- BANK0_BASE, 24'h000000, word base address of bank 0.
- BANK1_BASE, 24'h080000, word base address of bank 1.

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  synchronous active-low reset.
- frame_vsync  in  1  grey-stream frame sync; rising edge marks frame start.
- wr_fifo_level  in  11  words currently held in the write FIFO.
- rd_fifo_level  in  11  words currently held in the read FIFO.
- mem_wr_req  out  1  write-burst request, held until mem_ack.
- mem_rd_req  out  1  read-burst request, held until mem_ack.
- mem_addr  out  24  burst start word address, stable while a request is high.
- mem_burst_len  out  9  always BURST_LEN.
- mem_ack  in  1  one-cycle pulse: controller accepted the request.
- mem_done  in  1  one-cycle pulse: burst data transfer complete.
- wr_bank  out  1  bank currently being written.
- prev_valid  out  1  read bank holds a complete previous frame; gates sdr_rd/diff downstream.
- frame_cnt  out  16  completed-frame counter, wraps at 16'hFFFF.
- frame_drop  out  1  one-cycle pulse: frame boundary arrived before the write frame finished.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0, mem_burst_len = BURST_LEN, FSM = IDLE, wr_cnt = rd_cnt = 0, swap_pend = 0, last_grant = RD.
- Read bank is always ~wr_bank. Addresses are base(bank) + cnt.
- Edge detect: frame_vsync is registered once; vs_rise = vsync & ~vsync_d.
- Frame swap:
  - On vs_rise, set swap_pend.
  - The swap executes in the first cycle the FSM is in IDLE with swap_pend = 1. No burst is ever aborted.
  - Swap actions: wr_bank toggles; wr_cnt = rd_cnt = 0; frame_cnt += 1.
  - If wr_cnt == FRAME_WORDS at the swap: prev_valid = 1.
  - Otherwise: prev_valid = 0 and frame_drop pulses.
  - A vs_rise while swap_pend is already set is absorbed (one swap only).
  - Arbitration is not evaluated in a swap cycle.
- Eligibility (evaluated in IDLE only):
  - wr_elig = (wr_fifo_level >= BURST_LEN) && (wr_cnt < FRAME_WORDS).
  - rd_room = (rd_fifo_level <= FIFO_DEPTH - BURST_LEN) && prev_valid && (rd_cnt < FRAME_WORDS).
  - rd_urg = rd_room && (rd_fifo_level < RD_LOW_WM).
- Priority:
  1. rd_urg.
  2. Both wr_elig and rd_room: round-robin, grant the opposite of last_grant.
  3. Only one eligible: grant it.
  4. None eligible: stay in IDLE.
- FSM:
  - IDLE -> WR_REQ or RD_REQ: mem_addr registered on the same edge; the request is high the next cycle (1-cycle decision latency).
  - WR_REQ -> WR_WAIT on mem_ack: request drops the cycle after the ack.
  - WR_WAIT -> IDLE on mem_done: wr_cnt += BURST_LEN, last_grant = WR.
  - RD_REQ -> RD_WAIT on mem_ack: request drops the cycle after the ack.
  - RD_WAIT -> IDLE on mem_done: rd_cnt += BURST_LEN, last_grant = RD.
- Handshake edge cases:
  - mem_ack and mem_done in the same cycle while in *_REQ: go straight to IDLE and increment the counter.
  - mem_done in IDLE is ignored.
  - mem_wr_req and mem_rd_req are never high together.
- Counters: wr_cnt and rd_cnt are 19-bit and saturate at FRAME_WORDS. No further bursts of that type are issued until the next swap.
- Reset mid-burst: returns to IDLE immediately; the external controller is reset by the same rst_n.

Decomposition:
- Package fbs_pkg holds:
  - typedef enum fsm state {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT};
  - typedef grant_t {GRANT_WR, GRANT_RD};
  - function frame_words(h, v).
- One sub-module, fbs_arbiter: combinational priority/round-robin pick from (wr_elig, rd_room, rd_urg, last_grant).

Test Plan:
- Reset, then 2 frames with wr_fifo_level = 300 and rd_fifo_level = 0:
  - frame 1: only write bursts at addr 0, 256, …, 306944 (1200 bursts); prev_valid = 0.
  - after 2nd vs_rise: wr_bank = 1, prev_valid = 1, frame_cnt = 1.
- prev_valid = 1, wr_fifo_level = 300, rd_fifo_level = 500: grants alternate WR, RD, WR, RD; write addrs from 24'h080000, read addrs from 24'h000000.
- rd_fifo_level = 100 (< RD_LOW_WM) with the write also eligible: RD granted every decision until the level is >= 128.
- vs_rise during WR_WAIT: bank swap happens only after mem_done, in the next IDLE cycle; a second vs_rise in that window causes no extra swap.
- vs_rise after only 600 bursts written: frame_drop pulses once, prev_valid = 0, no read requests in the next frame.
- Same-cycle mem_ack + mem_done in RD_REQ: FSM is in IDLE the next cycle, rd_cnt += 256; rst_n low mid-burst: all outputs 0 on the following edge.
